// File: rtl/opb_cmd_master.sv
// ---------------------------------------------------------------------------
// opb_cmd_master
//
// OPB initiator for the local register segment (bridge controller and the
// pulse/sample/fault registers). It takes one command at a time from a host
// command source and runs it as a single write, a single read, or a
// poll-until-match read loop with a timeout. Read data and a status word are
// returned on a response handshake.
//
// Handshakes: a transfer happens on a rising OPB_CLK edge where valid and
// ready are both high. A producer holds valid and its payload stable until
// that edge. CMD_READY is high only in IDLE and not during reset. RSP_VALID
// is high only in RESP, and RSP_DATA/RSP_STATUS stay stable until the edge
// that samples RSP_READY high. RSP_READY is ignored at all other times.
//
// Ports
//   OPB_CLK, OPB_RST      clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY   command handshake
//   CMD_OP                00 write, 01 read, 10 poll, 11 illegal
//   CMD_ADDR/DATA/MASK    target register, write data or poll value, poll mask
//   RSP_VALID/RSP_READY   response handshake
//   RSP_DATA/RSP_STATUS   read data (0 for write), 00 OK / 01 timeout / 10 illegal
//   M_ADDR/M_WDATA        slave address and write data, held between commands
//   M_WE/M_RE             slave write and read strobes, never high together
//   M_RDATA               slave read data
//   DBG_STATE             current FSM state, for observation only
// ---------------------------------------------------------------------------
module opb_cmd_master #(
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_WAIT    = 1,
    parameter int POLL_GAP     = 16,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic                  OPB_CLK,
    input  logic                  OPB_RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_OP,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [31:0]           CMD_DATA,
    input  logic [31:0]           CMD_MASK,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_DATA,
    output logic [1:0]            RSP_STATUS,
    output logic [ADDR_WIDTH-1:0] M_ADDR,
    output logic [31:0]           M_WDATA,
    output logic                  M_WE,
    output logic                  M_RE,
    input  logic [31:0]           M_RDATA,
    output logic [2:0]            DBG_STATE
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_READ      = 3'd2;
    localparam logic [2:0] S_POLL_WAIT = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    // Each counter is wide enough to hold its parameter value, so none wraps.
    localparam int RW_W  = $clog2(READ_WAIT + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int PT_W  = $clog2(POLL_TIMEOUT + 1);

    localparam logic [RW_W-1:0]  RW_LAST  = RW_W'(READ_WAIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
    localparam logic [PT_W-1:0]  PT_MAX   = PT_W'(POLL_TIMEOUT);

    logic [2:0]            r_state;
    logic [1:0]            r_op;
    logic [31:0]           r_data;
    logic [31:0]           r_mask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rsp_data;
    logic [1:0]            r_rsp_status;
    logic [RW_W-1:0]       r_rd_cnt;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [PT_W-1:0]       r_poll_cnt;

    logic                  w_match;
    logic [PT_W-1:0]       w_poll_inc;

    // Only the masked bits take part in the compare; a zero mask always matches.
    assign w_match    = ((M_RDATA ^ r_data) & r_mask) == 32'h0;
    // r_poll_cnt stays below POLL_TIMEOUT while a read is in flight, so the
    // increment cannot overflow.
    assign w_poll_inc = r_poll_cnt + 1'b1;

    // Strobes decode straight from the state register: reset forces IDLE
    // asynchronously, so M_WE/M_RE drop the moment OPB_RST rises.
    assign CMD_READY  = (r_state == S_IDLE) && !OPB_RST;
    assign RSP_VALID  = (r_state == S_RESP);
    assign M_WE       = (r_state == S_WRITE);
    assign M_RE       = (r_state == S_READ);
    assign M_ADDR     = r_addr;
    assign M_WDATA    = r_wdata;
    assign RSP_DATA   = r_rsp_data;
    assign RSP_STATUS = r_rsp_status;
    assign DBG_STATE  = r_state;

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_state      <= S_IDLE;
            r_op         <= 2'b00;
            r_data       <= 32'h0;
            r_mask       <= 32'h0;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_rsp_data   <= 32'h0;
            r_rsp_status <= ST_OK;
            r_rd_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_poll_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // CMD_READY is always high here once out of reset.
                    if (CMD_VALID) begin
                        r_op   <= CMD_OP;
                        r_data <= CMD_DATA;
                        r_mask <= CMD_MASK;
                        r_addr <= CMD_ADDR;
                        case (CMD_OP)
                            OP_WRITE: begin
                                r_wdata <= CMD_DATA;
                                r_state <= S_WRITE;
                            end
                            OP_READ, OP_POLL: begin
                                r_rd_cnt   <= '0;
                                r_poll_cnt <= '0;
                                r_state    <= S_READ;
                            end
                            default: begin
                                r_rsp_data   <= 32'h0;
                                r_rsp_status <= ST_ILLEGAL;
                                r_state      <= S_RESP;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    r_rsp_data   <= 32'h0;
                    r_rsp_status <= ST_OK;
                    r_state      <= S_RESP;
                end

                S_READ: begin
                    if (r_rd_cnt == RW_LAST) begin
                        // Edge ending the last M_RE cycle: slave data is valid.
                        r_rsp_data <= M_RDATA;
                        r_rd_cnt   <= '0;
                        if (r_op != OP_POLL) begin
                            r_rsp_status <= ST_OK;
                            r_state      <= S_RESP;
                        end else begin
                            r_poll_cnt <= w_poll_inc;
                            if (w_match) begin
                                r_rsp_status <= ST_OK;
                                r_state      <= S_RESP;
                            end else if (w_poll_inc == PT_MAX) begin
                                r_rsp_status <= ST_TIMEOUT;
                                r_state      <= S_RESP;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= S_POLL_WAIT;
                            end
                        end
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end

                S_POLL_WAIT: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_rd_cnt  <= '0;
                        r_state   <= S_READ;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_RESP: begin
                    if (RSP_READY) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_opb_cmd_master
//
// Directed bench for opb_cmd_master. The main instance runs with
// READ_WAIT=3, POLL_GAP=4, POLL_TIMEOUT=8; a second instance with
// READ_WAIT=1 covers the single-cycle read. The slave is a small
// behavioural model driven from the bench's own count of finished read
// pulses. All DUT sampling happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_opb_cmd_master;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cmd_valid = 1'b0;
    logic        cmd_valid1 = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_addr = 4'h0;
    logic [31:0] cmd_data = 32'h0;
    logic [31:0] cmd_mask = 32'h0;
    logic        rsp_ready = 1'b0;
    logic        rsp_ready1 = 1'b0;

    logic        cmd_ready, rsp_valid, m_we, m_re;
    logic [31:0] rsp_data, m_wdata, m_rdata;
    logic [1:0]  rsp_status;
    logic [3:0]  m_addr;
    logic [2:0]  dbg_state;

    logic        cmd_ready1, rsp_valid1, m_we1, m_re1;
    logic [31:0] rsp_data1, m_wdata1, m_rdata1;
    logic [1:0]  rsp_status1;
    logic [3:0]  m_addr1;
    logic [2:0]  dbg_state1;

    opb_cmd_master #(
        .ADDR_WIDTH(4), .READ_WAIT(3), .POLL_GAP(4), .POLL_TIMEOUT(8)
    ) dut (
        .OPB_CLK(clk), .OPB_RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
        .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .CMD_MASK(cmd_mask),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
        .RSP_STATUS(rsp_status), .M_ADDR(m_addr), .M_WDATA(m_wdata),
        .M_WE(m_we), .M_RE(m_re), .M_RDATA(m_rdata), .DBG_STATE(dbg_state)
    );

    opb_cmd_master #(
        .ADDR_WIDTH(4), .READ_WAIT(1)
    ) dut1 (
        .OPB_CLK(clk), .OPB_RST(rst),
        .CMD_VALID(cmd_valid1), .CMD_READY(cmd_ready1), .CMD_OP(cmd_op),
        .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .CMD_MASK(cmd_mask),
        .RSP_VALID(rsp_valid1), .RSP_READY(rsp_ready1), .RSP_DATA(rsp_data1),
        .RSP_STATUS(rsp_status1), .M_ADDR(m_addr1), .M_WDATA(m_wdata1),
        .M_WE(m_we1), .M_RE(m_re1), .M_RDATA(m_rdata1), .DBG_STATE(dbg_state1)
    );

    // ---------------- slave model / monitor state ----------------
    int slave_mode = 0;   // 0: return 'h258, 1: 0 for three reads then 2, 2: always 0
    int re_done = 0;      // finished M_RE pulses since last clear
    int re_run = 0, re_w = 0;
    int gap_run = 0, gmin = 9999, gmax = 0;
    bit in_gap = 1'b0;
    int we_run = 0, we_w = 0, we_pulses = 0;
    int re1_run = 0, re1_w = 0, we1_seen = 0;
    bit overlap = 1'b0, addr_glitch = 1'b0;
    logic [3:0]  held_addr = 4'h0;
    logic [31:0] held_wdata = 32'h0;

    always_comb begin
        m_rdata = 32'h0;
        if (m_re) begin
            case (slave_mode)
                0:       m_rdata = 32'h258;
                1:       if (re_done >= 3) m_rdata = 32'h2;
                default: m_rdata = 32'h0;
            endcase
        end
    end
    assign m_rdata1 = m_re1 ? 32'h258 : 32'h0;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One cycle: go to the falling edge and update the bus monitor.
    task automatic tick();
        @(negedge clk);
        if (m_we && m_re) overlap = 1'b1;
        if (m_re) begin
            if (in_gap) begin
                if (gap_run < gmin) gmin = gap_run;
                if (gap_run > gmax) gmax = gap_run;
                in_gap = 1'b0;
            end
            if (re_run == 0) held_addr = m_addr;
            else if (m_addr !== held_addr) addr_glitch = 1'b1;
            re_run++;
        end else if (re_run > 0) begin
            re_w = re_run;
            re_run = 0;
            re_done++;
            in_gap = 1'b1;
            gap_run = 1;
        end else if (in_gap) begin
            gap_run++;
        end
        if (m_we) begin
            if (we_run == 0) begin
                held_addr  = m_addr;
                held_wdata = m_wdata;
            end else if (m_addr !== held_addr || m_wdata !== held_wdata) begin
                addr_glitch = 1'b1;
            end
            we_run++;
        end else if (we_run > 0) begin
            we_w = we_run;
            we_run = 0;
            we_pulses++;
        end
        if (m_re1) re1_run++;
        else if (re1_run > 0) begin
            re1_w = re1_run;
            re1_run = 0;
        end
        if (m_we1) we1_seen++;
    endtask

    task automatic mon_clear();
        re_done = 0; re_run = 0; re_w = 0;
        gap_run = 0; gmin = 9999; gmax = 0; in_gap = 1'b0;
        we_run = 0; we_w = 0; we_pulses = 0;
    endtask

    // Present a command at a falling edge and return at the falling edge of
    // cycle 1 (the first cycle after the accepting edge).
    task automatic send(input bit which, input logic [1:0] op, input logic [3:0] addr,
                        input logic [31:0] data, input logic [31:0] mask);
        int n;
        n = 0;
        while (!(which ? cmd_ready1 : cmd_ready) && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        if (which) cmd_valid1 = 1'b1;
        else       cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        cmd_valid1 = 1'b0;
    endtask

    // Count cycles from the accepting edge until the response shows up.
    task automatic wait_rsp(input bit which, output int lat);
        lat = 1;
        while (!(which ? rsp_valid1 : rsp_valid) && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_rsp(input bit which);
        if (which) rsp_ready1 = 1'b1;
        else       rsp_ready  = 1'b1;
        tick();
        rsp_ready  = 1'b0;
        rsp_ready1 = 1'b0;
        check("rsp_valid_clear", which ? rsp_valid1 : rsp_valid, 32'd0);
        check("cmd_ready_back",  which ? cmd_ready1 : cmd_ready, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int lat;
        int n;
        bit seen;

        // Reset values
        tick();
        check("rst_cmd_ready", cmd_ready, 32'd0);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_status", rsp_status, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'h0);
        check("rst_m_we", m_we, 32'd0);
        check("rst_m_re", m_re, 32'd0);
        check("rst_state", dbg_state, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", cmd_ready, 32'd1);
        check("idle_cmd_ready1", cmd_ready1, 32'd1);

        // Write: op 00, addr 6, data 1
        mon_clear();
        send(1'b0, 2'b00, 4'h6, 32'h1, 32'h0);
        check("wr_cmd_ready_low", cmd_ready, 32'd0);
        check("wr_we_c1", m_we, 32'd1);
        check("wr_addr", m_addr, 32'h6);
        check("wr_wdata", m_wdata, 32'h1);
        check("wr_rsp_c1", rsp_valid, 32'd0);
        wait_rsp(1'b0, lat);
        check("wr_latency", lat, 32'd2);
        check("wr_we_width", we_w, 32'd1);
        check("wr_status", rsp_status, 32'd0);
        check("wr_data", rsp_data, 32'h0);
        check("wr_resp_state", dbg_state, 32'd4);
        finish_rsp(1'b0);

        // Read, READ_WAIT=3: addr 8, slave returns 'h258
        mon_clear();
        slave_mode = 0;
        send(1'b0, 2'b01, 4'h8, 32'hDEAD_BEEF, 32'h0);
        check("rd_addr", m_addr, 32'h8);
        check("rd_wdata_kept", m_wdata, 32'h1);
        wait_rsp(1'b0, lat);
        check("rd_latency", lat, 32'd4);
        check("rd_re_width", re_w, 32'd3);
        check("rd_data", rsp_data, 32'h258);
        check("rd_status", rsp_status, 32'd0);
        finish_rsp(1'b0);

        // Read, READ_WAIT=1 on the second instance
        send(1'b1, 2'b01, 4'h8, 32'h0, 32'h0);
        wait_rsp(1'b1, lat);
        check("rd1_latency", lat, 32'd2);
        check("rd1_re_width", re1_w, 32'd1);
        check("rd1_data", rsp_data1, 32'h258);
        check("rd1_status", rsp_status1, 32'd0);
        check("rd1_addr", m_addr1, 32'h8);
        check("rd1_wdata", m_wdata1, 32'h0);
        check("rd1_resp_state", dbg_state1, 32'd4);
        finish_rsp(1'b1);

        // Poll: match on 4th read -> 1 + 4*3 + 3*4 = 25
        mon_clear();
        slave_mode = 1;
        send(1'b0, 2'b10, 4'h5, 32'h2, 32'h2);
        wait_rsp(1'b0, lat);
        check("poll_latency", lat, 32'd25);
        check("poll_reads", re_done, 32'd4);
        check("poll_gap_min", gmin, 32'd4);
        check("poll_gap_max", gmax, 32'd4);
        check("poll_re_width", re_w, 32'd3);
        check("poll_status", rsp_status, 32'd0);
        check("poll_data", rsp_data, 32'h2);
        finish_rsp(1'b0);

        // Poll timeout: 8 reads -> 1 + 8*3 + 7*4 = 53
        mon_clear();
        slave_mode = 2;
        send(1'b0, 2'b10, 4'h5, 32'h1, 32'h1);
        wait_rsp(1'b0, lat);
        check("tmo_latency", lat, 32'd53);
        check("tmo_reads", re_done, 32'd8);
        check("tmo_status", rsp_status, 32'd1);
        check("tmo_data", rsp_data, 32'h0);
        finish_rsp(1'b0);

        // Mask 0 matches on the first read even with mismatching data
        mon_clear();
        slave_mode = 2;
        send(1'b0, 2'b10, 4'h2, 32'hFFFF_FFFF, 32'h0);
        wait_rsp(1'b0, lat);
        check("mask0_latency", lat, 32'd4);
        check("mask0_reads", re_done, 32'd1);
        check("mask0_status", rsp_status, 32'd0);
        finish_rsp(1'b0);

        // Illegal op: no bus activity, response held while RSP_READY=0
        mon_clear();
        send(1'b0, 2'b11, 4'h3, 32'h1234, 32'h0);
        wait_rsp(1'b0, lat);
        check("ill_latency", lat, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("ill_hold_valid", rsp_valid, 32'd1);
        check("ill_status", rsp_status, 32'd2);
        check("ill_data", rsp_data, 32'h0);
        check("ill_no_re", re_done + re_run, 32'd0);
        check("ill_no_we", we_pulses + we_run, 32'd0);
        finish_rsp(1'b0);

        // Reset during POLL_WAIT
        mon_clear();
        slave_mode = 2;
        send(1'b0, 2'b10, 4'h5, 32'h1, 32'h1);
        n = 0;
        while (re_done == 0 && n < 50) begin
            tick();
            n++;
        end
        check("pw_first_read", re_done, 32'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("pw_rst_re", m_re, 32'd0);
        check("pw_rst_valid", rsp_valid, 32'd0);
        check("pw_rst_state", dbg_state, 32'd0);
        check("pw_rst_ready", cmd_ready, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid || m_re) seen = 1'b1;
        end
        check("pw_quiet_after", seen, 32'd0);

        // Reset while M_RE is high
        send(1'b0, 2'b10, 4'h5, 32'h1, 32'h1);
        check("re_rst_pre", m_re, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("re_rst_re", m_re, 32'd0);
        check("re_rst_valid", rsp_valid, 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid || m_re) seen = 1'b1;
        end
        check("re_quiet_after", seen, 32'd0);

        // Write after reset completes normally
        mon_clear();
        send(1'b0, 2'b00, 4'h3, 32'hA5A5_0F0F, 32'h0);
        check("pr_addr", m_addr, 32'h3);
        check("pr_wdata", m_wdata, 32'hA5A5_0F0F);
        wait_rsp(1'b0, lat);
        check("pr_latency", lat, 32'd2);
        check("pr_we_width", we_w, 32'd1);
        check("pr_status", rsp_status, 32'd0);
        finish_rsp(1'b0);

        // Whole-run bus properties
        check("never_we_and_re", overlap, 32'd0);
        check("no_bus_glitch", addr_glitch, 32'd0);
        check("dut1_never_we", we1_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opb_cmd_master.md
Name: opb_cmd_master

Overview:
- OPB initiator that drives the register slaves on the local OPB segment (bridge controller, pulse/sample/fault registers).
- Takes one command at a time from a host-side command source, such as a UART/command parser, over a valid/ready handshake.
- Executes single writes, single reads, or poll-until-match reads with a timeout against the slave register map.
- Returns read data and a status word through a response handshake.

Parameters:
- ADDR_WIDTH, 4, width of OPB register address.
- READ_WAIT, 1, cycles M_RE is held before read data is captured; legal range 1..15.
- POLL_GAP, 16, idle cycles between successive poll reads; legal range 1..65535.
- POLL_TIMEOUT, 1024, maximum number of poll reads before reporting timeout; legal range 1..65535.

Ports:
- OPB_CLK  in  1  single clock; all logic on posedge.
- OPB_RST  in  1  reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  2  00 write, 01 read, 10 poll, 11 illegal.
- CMD_ADDR  in  ADDR_WIDTH  target register address.
- CMD_DATA  in  32  write data, or poll compare value.
- CMD_MASK  in  32  poll compare mask; ignored for write and read.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed.
- RSP_DATA  out  32  captured read data; 0 for write.
- RSP_STATUS  out  2  00 OK, 01 poll timeout, 10 illegal op.
- M_ADDR  out  ADDR_WIDTH  to slave OPB_ADDR.
- M_WDATA  out  32  to slave OPB_DI.
- M_WE  out  1  to slave OPB_WE.
- M_RE  out  1  to slave OPB_RE.
- M_RDATA  in  32  from slave OPB_DO, the wired tri-state bus.

Behaviour:
- Clock and reset: one clock, OPB_CLK; OPB_RST is asynchronous, active-high.
- Reset values:
  - State goes to IDLE.
  - CMD_READY=0 during reset, then 1 on the first cycle in IDLE.
  - RSP_VALID=0, RSP_DATA=0, RSP_STATUS=00.
  - M_ADDR=0, M_WDATA=0, M_WE=0, M_RE=0.
  - Poll and gap counters cleared.
- Reset asserted mid-transaction aborts the transaction immediately. M_WE and M_RE drop asynchronously. No response is produced.
- States: IDLE, WRITE, READ, POLL_WAIT, RESP.
- IDLE:
  - CMD_READY=1 only in IDLE.
  - On CMD_VALID&CMD_READY: latch op/addr/data/mask, load M_ADDR from CMD_ADDR, and load M_WDATA from CMD_DATA (write only, else unchanged).
  - Next state: WRITE (op 00), READ (op 01/10, poll count cleared), or RESP with status 10 and data 0 (op 11).
- WRITE: M_WE=1 for exactly one cycle with M_ADDR/M_WDATA stable, then RESP with status 00 and RSP_DATA=0.
- READ:
  - M_RE=1 for READ_WAIT cycles. On the posedge ending the last cycle, capture M_RDATA into RSP_DATA.
  - Read op: go to RESP, status 00.
  - Poll op: increment poll count, then compare (M_RDATA & mask) with (data & mask).
    - Match: RESP, status 00.
    - Mismatch with count==POLL_TIMEOUT: RESP, status 01; RSP_DATA holds the last read value.
    - Otherwise: POLL_WAIT.
- POLL_WAIT: M_RE=0 for POLL_GAP cycles, then READ.
- RESP: RSP_VALID=1, with RSP_DATA/RSP_STATUS held stable until RSP_READY is sampled high; then RSP_VALID=0 and go to IDLE. RSP_READY is ignored outside RESP.
- Latency from command acceptance edge:
  - Write: WE on cycle 1, RSP_VALID on cycle 2.
  - Read: RSP_VALID on cycle 1+READ_WAIT.
  - Poll matching on the n-th read: 1 + n*READ_WAIT + (n-1)*POLL_GAP cycles to RSP_VALID.
- M_WE and M_RE are never high together. Both are 0 in IDLE, POLL_WAIT and RESP.
- M_ADDR and M_WDATA hold their last values between commands; no glitches while WE/RE are high.
- Mask 0 matches on the first poll read.
- Counters are sized to hold their parameter value; no wrap-around is permitted.

Test Plan:
- Reset, then write op 00, addr 4'h6, data 1 -> CMD_READY low next cycle; M_WE high exactly 1 cycle with M_ADDR=6, M_WDATA=1; RSP_VALID on cycle 2 with status 00 and data 0; CMD_READY back after RSP_READY.
- Read op 01, addr 4'h8, slave model drives 32'h258 while M_RE=1 (READ_WAIT=1 and 3) -> RSP_DATA=32'h258, status 00; M_RE width equals READ_WAIT.
- Poll addr 4'h5, mask 2, data 2; slave returns 0 for 3 reads then 2 (POLL_GAP=4) -> exactly 4 RE pulses, each pair separated by 4 idle cycles; status 00, RSP_DATA=2.
- Poll with POLL_TIMEOUT=8, slave always returns 0, mask 1, data 1 -> 8 reads then status 01, RSP_DATA=0.
- Op 11 -> no WE/RE activity; status 10; RSP_VALID held for 5 cycles while RSP_READY=0, then cleared the cycle after RSP_READY.
- Assert OPB_RST during a poll's POLL_WAIT and again while M_RE=1 -> M_RE drops immediately; RSP_VALID stays 0; a new write after reset completes normally.
